// File: rtl/mlp_layer_sequencer_pkg.sv
// Shared definitions for the MLP layer sequencer.
//   state_e   : sequencer FSM states, in the order they are visited
//   idx_width : address width needed to index n elements (at least 1 bit)
package mlp_layer_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_STREAM,
      ST_DRAIN,
      ST_RELU,
      ST_DONE
   } state_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mlp_valid_delay_line.sv
// DEPTH-stage register pipeline carrying a {valid, value} pair. It models the
// weight-read latency so each element reaches the MAC together with its weight.
//   clk, rst_n : clock, asynchronous active-low reset (clears every stage)
//   in_vld_i   : beat valid entering stage 0
//   in_val_i   : beat value entering stage 0
//   out_vld_o  : valid leaving the last stage
//   out_val_o  : value leaving the last stage
module mlp_valid_delay_line #(
   parameter int DEPTH = 1,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_vld_i,
   input  logic [W-1:0] in_val_i,
   output logic         out_vld_o,
   output logic [W-1:0] out_val_o
);

   logic [DEPTH-1:0]        vld_q;
   logic [DEPTH-1:0][W-1:0] val_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         val_q <= '0;
      end else begin
         vld_q[0] <= in_vld_i;
         val_q[0] <= in_val_i;
         for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            val_q[i] <= val_q[i-1];
         end
      end
   end

   assign out_vld_o = vld_q[DEPTH-1];
   assign out_val_o = val_q[DEPTH-1];

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Control stage for one MLP layer: accepts a vector, clears the accumulators,
// streams elements with their weight addresses, waits for the datapath to
// settle, strobes ReLU/capture and holds out_valid until acknowledged.
//   in_valid/in_ready/in_vec_flat : input vector handshake (element k at k*IN_WIDTH)
//   layer_start       : one-cycle accumulator clear
//   layer_input_index : weight read address
//   layer_input_value : element aligned with layer_valid (0 otherwise)
//   layer_valid       : MAC enable
//   layer_relu_en     : one-cycle output-capture strobe
//   out_valid/out_ready : result handshake
//   busy              : high whenever not idle
module mlp_layer_sequencer
   import mlp_layer_sequencer_pkg::*;
#(
   parameter int N_INPUTS    = 4,
   parameter int IN_WIDTH    = 16,
   parameter int RD_LATENCY  = 1,
   parameter int MAC_LATENCY = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [N_INPUTS*IN_WIDTH-1:0] in_vec_flat,
   output logic                         layer_start,
   output logic [$clog2(N_INPUTS)-1:0]  layer_input_index,
   output logic [IN_WIDTH-1:0]          layer_input_value,
   output logic                         layer_valid,
   output logic                         layer_relu_en,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         busy
);

   localparam int IDX_W     = idx_width(N_INPUTS);
   // Cycles after the last index before the final beat is in the accumulator.
   localparam int DRAIN_CYC = RD_LATENCY + MAC_LATENCY - 1;
   localparam int DRN_W     = idx_width(DRAIN_CYC + 1);

   state_e                             state_q, state_d;
   logic [N_INPUTS-1:0][IN_WIDTH-1:0]  vec_q, vec_d;
   logic [IDX_W-1:0]                   idx_q, idx_d;
   logic [DRN_W-1:0]                   drn_q, drn_d;
   logic                               beat_vld;
   logic [IN_WIDTH-1:0]                beat_val;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         idx_q   <= '0;
         drn_q   <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         idx_q   <= idx_d;
         drn_q   <= drn_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      vec_d         = vec_q;
      idx_d         = idx_q;
      drn_d         = drn_q;
      in_ready      = 1'b0;
      layer_start   = 1'b0;
      layer_relu_en = 1'b0;
      out_valid     = 1'b0;
      beat_vld      = 1'b0;
      beat_val      = '0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               vec_d   = in_vec_flat;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            layer_start = 1'b1;
            idx_d       = '0;
            state_d     = ST_STREAM;
         end
         ST_STREAM: begin
            beat_vld = 1'b1;
            beat_val = vec_q[idx_q];
            if (idx_q == IDX_W'(N_INPUTS - 1)) begin
               drn_d   = '0;
               state_d = (DRAIN_CYC == 0) ? ST_RELU : ST_DRAIN;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            // Index stays on its last value while the pipeline empties.
            if (drn_q == DRN_W'(DRAIN_CYC - 1)) state_d = ST_RELU;
            else                                drn_d   = drn_q + 1'b1;
         end
         ST_RELU: begin
            layer_relu_en = 1'b1;
            state_d       = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               idx_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   mlp_valid_delay_line #(
      .DEPTH (RD_LATENCY),
      .W     (IN_WIDTH)
   ) u_dly (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_vld_i  (beat_vld),
      .in_val_i  (beat_val),
      .out_vld_o (layer_valid),
      .out_val_o (layer_input_value)
   );

   assign layer_input_index = idx_q;
   assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Scoreboard bench for mlp_layer_sequencer, run on two parameter sets side by
// side. Each accepted vector schedules its expected start/beat/relu/done
// cycles from the timing rules; a negedge monitor pops them as the DUT shows them.
module tb_mlp_layer_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   function automatic void chk(input string name, input logic signed [63:0] act,
                               input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   for (genvar g = 0; g < 2; g++) begin : gen_cfg
      localparam int N   = (g == 0) ? 4 : 8;
      localparam int RD  = (g == 0) ? 1 : 2;
      localparam int MAC = (g == 0) ? 1 : 2;
      localparam int W   = 16;
      localparam int IW  = $clog2(N);
      typedef logic [N-1:0][W-1:0] vec_t;

      logic          rst_n, in_valid, in_ready, out_valid, out_ready, busy;
      logic          layer_start, layer_valid, layer_relu_en;
      vec_t          in_vec;
      logic [IW-1:0] layer_input_index;
      logic [W-1:0]  layer_input_value;
      bit            done_f = 1'b0;
      bit            b2b_mode = 1'b0;
      int            cyc = 0;

      mlp_layer_sequencer #(
         .N_INPUTS(N), .IN_WIDTH(W), .RD_LATENCY(RD), .MAC_LATENCY(MAC)
      ) u_dut (
         .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
         .in_vec_flat(in_vec), .layer_start(layer_start),
         .layer_input_index(layer_input_index), .layer_input_value(layer_input_value),
         .layer_valid(layer_valid), .layer_relu_en(layer_relu_en),
         .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
      );

      always @(posedge clk) cyc++;

      // ---------------- scoreboard / monitor ----------------
      int           start_q[$], relu_q[$], done_q[$];
      int           beat_cyc_q[$], beat_idx_q[$];
      logic [W-1:0] beat_val_q[$];
      int           idx_hist[int];
      int           nbeats, exit_cyc, b2b_n;
      bit           ov_prev, exit_pend;

      always @(negedge clk) begin
         if (!rst_n) begin
            start_q.delete(); relu_q.delete(); done_q.delete();
            beat_cyc_q.delete(); beat_idx_q.delete(); beat_val_q.delete();
            nbeats = 0; ov_prev = 0; exit_pend = 0; b2b_n = 0;
         end else begin
            idx_hist[cyc] = int'(layer_input_index);
            chk($sformatf("c%0d_exclusive", g), $onehot0({layer_start, layer_valid, layer_relu_en}), 1);
            chk($sformatf("c%0d_busy_vs_idle", g), busy, !in_ready);
            if (exit_pend) begin
               chk($sformatf("c%0d_ov_drop", g), out_valid, 0);
               chk($sformatf("c%0d_ready_after_done", g), in_ready, 1);
               exit_pend = 0;
            end
            if (in_valid && in_ready) begin
               start_q.push_back(cyc + 1);
               for (int k = 0; k < N; k++) begin
                  beat_cyc_q.push_back(cyc + 2 + k + RD);
                  beat_idx_q.push_back(k);
                  beat_val_q.push_back(in_vec[k]);
               end
               relu_q.push_back(cyc + 1 + N + RD + MAC);
               done_q.push_back(cyc + 2 + N + RD + MAC);
               if (b2b_mode) begin
                  if (b2b_n > 0) chk($sformatf("c%0d_b2b_hs_cycle", g), cyc, exit_cyc + 1);
                  b2b_n++;
               end else b2b_n = 0;
            end
            if (layer_start) begin
               if (start_q.size() == 0) chk($sformatf("c%0d_unexpected_start", g), cyc, -1);
               else chk($sformatf("c%0d_start_cycle", g), cyc, start_q.pop_front());
               nbeats = 0;
            end
            if (layer_valid) begin
               if (beat_cyc_q.size() == 0) chk($sformatf("c%0d_unexpected_beat", g), cyc, -1);
               else begin
                  chk($sformatf("c%0d_beat_cycle", g), cyc, beat_cyc_q.pop_front());
                  chk($sformatf("c%0d_beat_value", g), $signed(layer_input_value),
                      $signed(beat_val_q.pop_front()));
                  chk($sformatf("c%0d_beat_index", g), idx_hist[cyc-RD], beat_idx_q.pop_front());
               end
               nbeats++;
            end else begin
               chk($sformatf("c%0d_idle_value", g), layer_input_value, 0);
            end
            if (layer_relu_en) begin
               if (relu_q.size() == 0) chk($sformatf("c%0d_unexpected_relu", g), cyc, -1);
               else chk($sformatf("c%0d_relu_cycle", g), cyc, relu_q.pop_front());
               chk($sformatf("c%0d_beats_per_vec", g), nbeats, N);
            end
            if (out_valid && !ov_prev) begin
               if (done_q.size() == 0) chk($sformatf("c%0d_unexpected_out_valid", g), cyc, -1);
               else chk($sformatf("c%0d_out_valid_cycle", g), cyc, done_q.pop_front());
            end
            if (out_valid && out_ready) begin
               exit_pend = 1;
               exit_cyc  = cyc;
            end
            ov_prev = out_valid;
         end
      end

      // ---------------- stimulus ----------------
      function automatic vec_t rvec();
         vec_t r;
         for (int k = 0; k < N; k++) r[k] = W'($urandom);
         return r;
      endfunction

      task automatic send(input vec_t v, input int dly);
         bit ok;
         @(posedge clk); #1;
         in_vec = v; in_valid = 1'b1;
         if (dly < 0) out_ready = 1'b1;
         ok = 0;
         for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = in_ready; end
         chk($sformatf("c%0d_hs_timeout", g), ok, 1);
         @(posedge clk); #1 in_valid = 1'b0;
         ok = 0;
         for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = out_valid; end
         chk($sformatf("c%0d_done_timeout", g), ok, 1);
         if (dly >= 0) begin
            // Hold off the consumer while offering another vector that must be refused.
            for (int i = 0; i < dly; i++) begin
               chk($sformatf("c%0d_bp_out_valid", g), out_valid, 1);
               chk($sformatf("c%0d_bp_in_ready", g), in_ready, 0);
               @(posedge clk); #1 in_valid = 1'b1;
               @(negedge clk);
            end
            @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
         end
         @(posedge clk); #1 out_ready = 1'b0;
      endtask

      initial begin
         int   dir[4];
         vec_t v;
         int   hs;
         bit   ok;
         dir = '{1, -2, 3, 4};
         rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
         #1 rst_n = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         chk($sformatf("c%0d_rst_in_ready", g), in_ready, 1);
         chk($sformatf("c%0d_rst_outputs", g),
             {layer_start, layer_valid, layer_relu_en, out_valid, busy}, 0);
         chk($sformatf("c%0d_rst_index", g), layer_input_index, 0);
         chk($sformatf("c%0d_rst_value", g), layer_input_value, 0);
         @(posedge clk); #2 rst_n = 1'b1;

         // directed vector, consumer always ready
         for (int k = 0; k < N; k++) v[k] = (g == 0) ? W'(dir[k % 4]) : W'($urandom);
         send(v, -1);
         // backpressure: out_ready low for 5 cycles of out_valid
         send(rvec(), 5);

         // back-to-back with in_valid and out_ready held high
         b2b_mode = 1'b1;
         @(posedge clk); #1 out_ready = 1'b1; in_valid = 1'b1; in_vec = rvec();
         hs = 0;
         for (int i = 0; i < 300 && hs < 3; i++) begin
            @(negedge clk);
            if (in_ready) begin hs++; @(posedge clk); #1 in_vec = rvec(); end
         end
         chk($sformatf("c%0d_b2b_count", g), hs, 3);
         in_valid = 1'b0;
         ok = 0;
         for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = !busy; end
         chk($sformatf("c%0d_b2b_idle_timeout", g), ok, 1);
         @(posedge clk); #1 out_ready = 1'b0; b2b_mode = 1'b0;

         // randomized traffic with random consumer delay and idle gaps
         for (int n = 0; n < 6; n++) begin
            send(rvec(), int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
         end

         // reset pulse in the middle of streaming
         @(posedge clk); #1 in_vec = rvec(); in_valid = 1'b1;
         ok = 0;
         for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = in_ready; end
         chk($sformatf("c%0d_rst_hs_timeout", g), ok, 1);
         @(posedge clk); #1 in_valid = 1'b0;
         repeat (3) @(posedge clk);
         #2 rst_n = 1'b0;
         #1;
         chk($sformatf("c%0d_midrst_outputs", g),
             {layer_start, layer_valid, layer_relu_en, out_valid, busy}, 0);
         chk($sformatf("c%0d_midrst_value", g), layer_input_value, 0);
         repeat (2) @(negedge clk);
         @(posedge clk); #2 rst_n = 1'b1;
         #1 chk($sformatf("c%0d_midrst_in_ready", g), in_ready, 1);
         // any relu/out_valid here would hit an empty scoreboard queue
         repeat (30) @(posedge clk);
         send(rvec(), 1);

         repeat (10) @(posedge clk);
         chk($sformatf("c%0d_pending_beats", g), beat_cyc_q.size(), 0);
         chk($sformatf("c%0d_pending_relu", g), relu_q.size(), 0);
         chk($sformatf("c%0d_pending_done", g), done_q.size(), 0);
         done_f = 1'b1;
      end
   end

   initial begin
      fork
         wait (gen_cfg[0].done_f && gen_cfg[1].done_f);
         #200000;
      join_any
      chk("sim_timeout", gen_cfg[0].done_f && gen_cfg[1].done_f, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
